wb_trace_checker: RTL and testbench

//   Consumer of the core's writeback trace port (debug_wb_*). Compares every committed

---
 rtl/wb_trace_checker_if.sv | 40 ++++
 rtl/wb_trace_checker.sv | 114 +++++++++++
 tb/tb_wb_trace_checker.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_trace_checker_if.sv
// Writeback trace and golden-trace stream bundle for wb_trace_checker.
// The master side is the core/bench; the slave side is the checker.
interface wb_trace_checker_if;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        ref_valid;
  logic        ref_ready;
  logic [31:0] ref_pc;
  logic [4:0]  ref_wnum;
  logic [31:0] ref_wdata;
  logic        ref_last;

  modport master (
    output debug_wb_pc,
    output debug_wb_rf_we,
    output debug_wb_rf_wnum,
    output debug_wb_rf_wdata,
    output ref_valid,
    output ref_pc,
    output ref_wnum,
    output ref_wdata,
    output ref_last,
    input  ref_ready
  );

  modport slave (
    input  debug_wb_pc,
    input  debug_wb_rf_we,
    input  debug_wb_rf_wnum,
    input  debug_wb_rf_wdata,
    input  ref_valid,
    input  ref_pc,
    input  ref_wnum,
    input  ref_wdata,
    input  ref_last,
    output ref_ready
  );
endinterface

// File: rtl/wb_trace_checker.sv
// Compares committed register writes against a buffered golden trace
// and reports PASS on the last entry or the first divergence.
module wb_trace_checker #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  wb_trace_checker_if.slave bus,
  output logic [1:0]       state,
  output logic [1:0]       err_code,
  output logic [31:0]      err_pc,
  output logic [31:0]      err_exp_wdata,
  output logic [31:0]      err_got_wdata,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  logic [31:0] pc_q    [FIFO_DEPTH];
  logic [4:0]  wnum_q  [FIFO_DEPTH];
  logic [31:0] wdata_q [FIFO_DEPTH];
  logic        last_q  [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic        push;
  logic        pop;
  logic        commit;
  logic        empty;
  logic        hit;
  logic [31:0] mask;

  assign bus.ref_ready = resetn & (count < FULL);
  assign push  = bus.ref_valid & bus.ref_ready;
  assign empty = (count == '0);

  assign commit = (|bus.debug_wb_rf_we)
                & (|bus.debug_wb_rf_wnum)
                & (state == ST_RUN);
  assign pop = commit & ~empty;

  always_comb begin
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[i*8 +: 8] = {8{bus.debug_wb_rf_we[i]}};
    end
  end

  // Only the enabled bytes of the write data take part in the check.
  assign hit = (bus.debug_wb_pc == pc_q[rd_ptr])
             & (bus.debug_wb_rf_wnum == wnum_q[rd_ptr])
             & (((bus.debug_wb_rf_wdata ^ wdata_q[rd_ptr])
                 & mask) == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]    <= bus.ref_pc;
      wnum_q[wr_ptr]  <= bus.ref_wnum;
      wdata_q[wr_ptr] <= bus.ref_wdata;
      last_q[wr_ptr]  <= bus.ref_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= ST_RUN;
      err_code      <= 2'd0;
      err_pc        <= '0;
      err_exp_wdata <= '0;
      err_got_wdata <= '0;
      match_cnt     <= '0;
    end else if (commit) begin
      if (empty) begin
        state         <= ST_FAIL;
        err_code      <= 2'd2;
        err_pc        <= bus.debug_wb_pc;
        err_exp_wdata <= '0;
        err_got_wdata <= bus.debug_wb_rf_wdata;
      end else if (hit) begin
        match_cnt <= match_cnt + CNT_W'(1);
        if (last_q[rd_ptr]) state <= ST_PASS;
      end else begin
        state         <= ST_FAIL;
        err_code      <= 2'd1;
        err_pc        <= bus.debug_wb_pc;
        err_exp_wdata <= wdata_q[rd_ptr];
        err_got_wdata <= bus.debug_wb_rf_wdata;
      end
    end
  end
endmodule

// File: tb/tb_wb_trace_checker.sv
// Bench for wb_trace_checker: directed table, corner sequences and
// random traffic against a queue-based reference model.
module tb_wb_trace_checker;
  localparam int D = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  wb_trace_checker_if bus ();

  logic [1:0]  state;
  logic [1:0]  err_code;
  logic [31:0] err_pc;
  logic [31:0] err_exp_wdata;
  logic [31:0] err_got_wdata;
  logic [31:0] match_cnt;

  wb_trace_checker #(.FIFO_DEPTH(D), .CNT_W(32)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus.slave),
    .state         (state),
    .err_code      (err_code),
    .err_pc        (err_pc),
    .err_exp_wdata (err_exp_wdata),
    .err_got_wdata (err_got_wdata),
    .match_cnt     (match_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        last;
  } ent_t;

  typedef struct {
    logic        rst;
    logic [3:0]  we;
    logic [4:0]  wnum;
    logic [31:0] pc;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rpc;
    logic [4:0]  rwnum;
    logic [31:0] rwdata;
    logic        rlast;
    logic [1:0]  e_st;
    logic [1:0]  e_code;
    logic [31:0] e_cnt;
    logic [31:0] e_pc;
    logic [31:0] e_exp;
    logic [31:0] e_got;
  } vec_t;

  // Reference model state
  ent_t        q[$];
  logic [1:0]  m_st;
  logic [1:0]  m_code;
  logic [31:0] m_pc, m_exp, m_got, m_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] we,
                       input logic [4:0] wnum, input logic [31:0] pc,
                       input logic [31:0] wdata, input logic rv,
                       input logic [31:0] rpc, input logic [4:0] rwnum,
                       input logic [31:0] rwdata, input logic rlast);
    resetn                = rst;
    bus.debug_wb_rf_we    = we;
    bus.debug_wb_rf_wnum  = wnum;
    bus.debug_wb_pc       = pc;
    bus.debug_wb_rf_wdata = wdata;
    bus.ref_valid         = rv;
    bus.ref_pc            = rpc;
    bus.ref_wnum          = rwnum;
    bus.ref_wdata         = rwdata;
    bus.ref_last          = rlast;
  endtask

  function automatic logic [31:0] bmask(logic [3:0] we);
    logic [31:0] m = 0;
    for (int i = 0; i < 4; i++)
      if (we[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  // Applies the spec rules for one clock edge to the model.
  task automatic model_step();
    ent_t h, e;
    bit ready, is_commit;
    if (!resetn) begin
      q.delete();
      m_st = 0; m_code = 0; m_pc = 0;
      m_exp = 0; m_got = 0; m_cnt = 0;
      return;
    end
    ready = q.size() < D;
    is_commit = bus.debug_wb_rf_we != 0 && bus.debug_wb_rf_wnum != 0
                && m_st == 0;
    if (is_commit) begin
      if (q.size() == 0) begin
        m_st = 2; m_code = 2; m_pc = bus.debug_wb_pc;
        m_exp = 0; m_got = bus.debug_wb_rf_wdata;
      end else begin
        h = q.pop_front();
        if (bus.debug_wb_pc == h.pc && bus.debug_wb_rf_wnum == h.wnum &&
            ((bus.debug_wb_rf_wdata ^ h.wdata) &
             bmask(bus.debug_wb_rf_we)) == 0) begin
          m_cnt = m_cnt + 1;
          if (h.last) m_st = 1;
        end else begin
          m_st = 2; m_code = 1; m_pc = bus.debug_wb_pc;
          m_exp = h.wdata; m_got = bus.debug_wb_rf_wdata;
        end
      end
    end
    if (bus.ref_valid && ready) begin
      e.pc = bus.ref_pc; e.wnum = bus.ref_wnum;
      e.wdata = bus.ref_wdata; e.last = bus.ref_last;
      q.push_back(e);
    end
  endtask

  // One clock with the currently driven inputs, checked against the model.
  task automatic cycle();
    #1;
    chk("ref_ready", 32'(bus.ref_ready),
        32'(resetn && q.size() < D));
    model_step();
    @(posedge clk);
    #1;
    chk("state", 32'(state), 32'(m_st));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("err_pc", err_pc, m_pc);
    chk("err_exp_wdata", err_exp_wdata, m_exp);
    chk("err_got_wdata", err_got_wdata, m_got);
    chk("match_cnt", match_cnt, m_cnt);
  endtask

  function automatic vec_t v(logic rst, logic [3:0] we, logic [4:0] wnum,
      logic [31:0] pc, logic [31:0] wdata, logic rv, logic [31:0] rpc,
      logic [4:0] rwnum, logic [31:0] rwdata, logic rlast,
      logic [1:0] e_st, logic [1:0] e_code, logic [31:0] e_cnt,
      logic [31:0] e_pc, logic [31:0] e_exp, logic [31:0] e_got);
    vec_t r;
    r.rst = rst; r.we = we; r.wnum = wnum; r.pc = pc; r.wdata = wdata;
    r.rv = rv; r.rpc = rpc; r.rwnum = rwnum; r.rwdata = rwdata;
    r.rlast = rlast; r.e_st = e_st; r.e_code = e_code; r.e_cnt = e_cnt;
    r.e_pc = e_pc; r.e_exp = e_exp; r.e_got = e_got;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    m_st = 0; m_code = 0; m_pc = 0; m_exp = 0; m_got = 0; m_cnt = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Three-entry trace ending in PASS
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0, 1,32'h1c000000,1,32'h11,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0, 1,32'h1c000004,2,32'h22,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0, 1,32'h1c000008,3,32'h33,1, 0,0,0,0,0,0));
    tbl.push_back(v(1,4'hf,1,32'h1c000000,32'h11, 0,0,0,0,0, 0,0,1,0,0,0));
    tbl.push_back(v(1,4'hf,2,32'h1c000004,32'h22, 0,0,0,0,0, 0,0,2,0,0,0));
    tbl.push_back(v(1,4'hf,3,32'h1c000008,32'h33, 0,0,0,0,0, 1,0,3,0,0,0));
    tbl.push_back(v(1,4'hf,3,32'h1c00000c,32'h44, 0,0,0,0,0, 1,0,3,0,0,0));
    // Byte-masked compare, then a field mismatch
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0, 1,32'h100,4,32'h12345678,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0, 1,32'h104,4,32'h12345678,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,4'h1,4,32'h100,32'hAAAAAA78, 0,0,0,0,0,
                    0,0,1,0,0,0));
    tbl.push_back(v(1,4'h1,4,32'h104,32'hAAAAAA79, 0,0,0,0,0,
                    2,1,1,32'h104,32'h12345678,32'hAAAAAA79));
    // Reset out of FAIL, then underflow
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,4'hf,5,32'h200,32'h55, 0,0,0,0,0,
                    2,2,0,32'h200,0,32'h55));
    // Non-commit writes do not pop
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0, 1,32'h300,6,32'h66,1, 0,0,0,0,0,0));
    tbl.push_back(v(1,4'h0,6,32'h300,32'h66, 0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,4'hf,0,32'h300,32'h66, 0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,4'hf,6,32'h300,32'h66, 0,0,0,0,0, 1,0,1,0,0,0));
    // Underflow with a same-cycle push
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,4'h3,7,32'h400,32'h77, 1,32'h400,7,32'h77,0,
                    2,2,0,32'h400,0,32'h77));

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].wnum, tbl[i].pc, tbl[i].wdata,
            tbl[i].rv, tbl[i].rpc, tbl[i].rwnum, tbl[i].rwdata,
            tbl[i].rlast);
      cycle();
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].e_st));
      chk($sformatf("tbl%0d_code", i), 32'(err_code),
          32'(tbl[i].e_code));
      chk($sformatf("tbl%0d_cnt", i), match_cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_pc", i), err_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_exp", i), err_exp_wdata, tbl[i].e_exp);
      chk($sformatf("tbl%0d_got", i), err_got_wdata, tbl[i].e_got);
    end

    // Fill to full, then pop while the stream keeps offering entries
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    for (int i = 0; i < D; i++) begin
      drive(1, 0, 0, 0, 0, 1, 32'(i * 4), 1, 32'(i), 0);
      #1 chk("fill_ready", 32'(bus.ref_ready), 1);
      cycle();
    end
    drive(1, 0, 0, 0, 0, 1, 32'h80, 1, 32'h80, 0);
    #1 chk("full_ready", 32'(bus.ref_ready), 0);
    cycle();
    drive(1, 4'hf, 1, 32'h0, 32'h0, 1, 32'h80, 1, 32'h80, 0);
    #1 chk("full_pop_ready", 32'(bus.ref_ready), 0);
    cycle();
    chk("full_pop_cnt", match_cnt, 1);
    drive(1, 4'hf, 1, 32'h4, 32'h1, 1, 32'h84, 1, 32'h84, 0);
    #1 chk("pushpop_ready", 32'(bus.ref_ready), 1);
    cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("pushpop_after", 32'(bus.ref_ready), 1);
    cycle();
    chk("pushpop_cnt", match_cnt, 2);

    // Random traffic; commits usually follow the model's head
    for (int n = 0; n < 4000; n++) begin
      logic [3:0]  we;
      logic [4:0]  wn;
      logic [31:0] pc, wd;
      int k;
      we = 0; wn = 0; pc = $urandom; wd = $urandom;
      k = $urandom_range(0, 9);
      if (k < 4) begin
        we = 4'($urandom_range(0, 15));
        wn = (we == 0) ? 5'($urandom) : 5'd0;
      end else if (k < 9 && q.size() != 0) begin
        we = 4'($urandom_range(1, 15));
        wn = q[0].wnum;
        pc = q[0].pc;
        wd = q[0].wdata ^ ($urandom & ~bmask(we));
      end else begin
        we = 4'($urandom_range(1, 15));
        wn = 5'($urandom_range(1, 31));
      end
      drive($urandom_range(0, 39) != 0, we, wn, pc, wd,
            1'($urandom), $urandom, 5'($urandom_range(1, 31)),
            $urandom, $urandom_range(0, 15) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
